// File: rtl/axi_lite_slave_mem.sv
// AXI-lite responder backed by a DEPTH x 32-bit register array with independent read/write FSMs.
// Define AXI_SLV_ASSERT_EN to compile the handshake-protocol assertions.
module axi_lite_slave_mem #(
    parameter int  DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        rready
);
    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t     wstate, wstate_n;
    rstate_t     rstate, rstate_n;
    logic [31:0] mem [DEPTH];

    logic        aw_hold, w_hold;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [31:0] cur_awaddr, cur_wdata;
    logic [3:0]  cur_wstrb;
    logic        w_in_range, r_in_range;
    logic [IDX_W-1:0] w_idx, r_idx;
    logic        unused_ok;

    assign awready = (wstate == W_IDLE) && !aw_hold;
    assign wready  = (wstate == W_IDLE) && !w_hold;
    assign bvalid  = (wstate == W_RESP);
    assign arready = (rstate == R_IDLE);
    assign rvalid  = (rstate == R_DATA);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // Commit once both halves are available, whether held from earlier or arriving this edge.
    assign commit = (wstate == W_IDLE) && (aw_hold || aw_hs) && (w_hold || w_hs);

    assign cur_awaddr = aw_hold ? aw_addr_q : awaddr;
    assign cur_wdata  = w_hold ? w_data_q : wdata;
    assign cur_wstrb  = w_hold ? w_strb_q : wstrb;

    assign w_in_range = (cur_awaddr[31:IDX_W+2] == '0);
    assign w_idx      = cur_awaddr[IDX_W+1:2];
    assign r_in_range = (araddr[31:IDX_W+2] == '0);
    assign r_idx      = araddr[IDX_W+1:2];
    assign unused_ok  = ^{cur_awaddr[1:0], araddr[1:0]};

    always_comb begin
        wstate_n = wstate;
        case (wstate)
            W_IDLE: if (commit) wstate_n = W_RESP;
            W_RESP: if (bready) wstate_n = W_IDLE;
            default: wstate_n = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_n = rstate;
        case (rstate)
            R_IDLE: if (arvalid) rstate_n = R_DATA;
            R_DATA: if (rready)  rstate_n = R_IDLE;
            default: rstate_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate    <= W_IDLE;
            rstate    <= R_IDLE;
            aw_hold   <= 1'b0;
            w_hold    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            rdata     <= '0;
        end else begin
            wstate <= wstate_n;
            rstate <= rstate_n;
            if (commit) begin
                aw_hold <= 1'b0;
                w_hold  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_hold   <= 1'b1;
                    aw_addr_q <= awaddr;
                end
                if (w_hs) begin
                    w_hold   <= 1'b1;
                    w_data_q <= wdata;
                    w_strb_q <= wstrb;
                end
            end
            // Nonblocking read of mem returns the pre-write word on a same-edge commit.
            if (ar_hs)
                rdata <= r_in_range ? mem[r_idx] : 32'h0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (commit && w_in_range) begin
            for (int b = 0; b < 4; b++)
                if (cur_wstrb[b])
                    mem[w_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
    end

`ifdef AXI_SLV_ASSERT_EN
    a_b_hold:  assert property (@(posedge clk) disable iff (reset)
                   bvalid && !bready |=> bvalid);
    a_r_hold:  assert property (@(posedge clk) disable iff (reset)
                   rvalid && !rready |=> rvalid && $stable(rdata));
    a_aw_hold: assert property (@(posedge clk) disable iff (reset)
                   awvalid && !awready |=> awvalid && $stable(awaddr));
    a_ar_hold: assert property (@(posedge clk) disable iff (reset)
                   arvalid && !arready |=> arvalid && $stable(araddr));
    a_b_aw:    assert property (@(posedge clk) disable iff (reset)
                   !(bvalid && awready));
`endif
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed bench for axi_lite_slave_mem: vector table of write/readback pairs plus
// hand-written split-write, backpressure, same-edge, sweep and mid-op reset sequences.
module tb_axi_lite_slave_mem;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;

    int checks = 0;
    int failures = 0;

    axi_lite_slave_mem #(.DEPTH(16)) dut (
        .clk(clk), .reset(reset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " awready"}, {31'h0, awready}, 32'h1);
        chk({tag, " wready"},  {31'h0, wready},  32'h1);
        chk({tag, " arready"}, {31'h0, arready}, 32'h1);
        chk({tag, " bvalid"},  {31'h0, bvalid},  32'h0);
        chk({tag, " rvalid"},  {31'h0, rvalid},  32'h0);
        chk({tag, " rdata"},   rdata,            32'h0);
    endtask

    // AW and W presented together; response expected exactly one cycle later.
    task automatic do_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk({nm, " bvalid lat1"}, {31'h0, bvalid}, 32'h1);
        chk({nm, " awready during B"}, {31'h0, awready}, 32'h0);
        @(negedge clk);
        chk({nm, " bvalid drop"}, {31'h0, bvalid}, 32'h0);
        bready = 1'b0;
    endtask

    task automatic do_read(input string nm, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk({nm, " rvalid lat1"}, {31'h0, rvalid}, 32'h1);
        chk({nm, " rdata"}, rdata, exp);
        @(negedge clk);
        chk({nm, " rvalid drop"}, {31'h0, rvalid}, 32'h0);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] sweep_exp;
        vecs[0] = '{"wr_rd_08",   32'h08,  32'hA5A5_1234, 4'hF,    32'hA5A5_1234};
        vecs[1] = '{"fill_04",    32'h04,  32'hFFFF_FFFF, 4'hF,    32'hFFFF_FFFF};
        vecs[2] = '{"strb_0101",  32'h04,  32'h0000_0000, 4'b0101, 32'hFF00_FF00};
        vecs[3] = '{"oor_40",     32'h40,  32'hDEAD_BEEF, 4'hF,    32'h0};
        vecs[4] = '{"strb_zero",  32'h3C,  32'h1234_5678, 4'h0,    32'h0};
        vecs[5] = '{"lowbits_3E", 32'h3E,  32'hCAFE_F00D, 4'b1100, 32'hCAFE_0000};
        vecs[6] = '{"oor_400",    32'h400, 32'h9999_9999, 4'hF,    32'h0};

        reset = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        #1;
        chk_reset_vals("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            do_write(vecs[i].name, vecs[i].addr, vecs[i].data, vecs[i].strb);
            do_read(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end

        // Split write: W at cycle 0, AW at cycle 3.
        @(negedge clk);
        wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            wvalid = 1'b0;
            chk($sformatf("split wready c%0d", c), {31'h0, wready}, 32'h0);
            chk($sformatf("split bvalid c%0d", c), {31'h0, bvalid}, 32'h0);
            if (c == 3) begin
                awaddr = 32'h0C; awvalid = 1'b1;
            end
        end
        @(negedge clk);
        awvalid = 1'b0;
        chk("split bvalid c4", {31'h0, bvalid}, 32'h1);
        @(negedge clk);
        bready = 1'b0;
        chk("split bvalid drop", {31'h0, bvalid}, 32'h0);
        do_read("split rd_0C", 32'h0C, 32'h1111_2222);

        // Backpressure with a same-edge write commit and read of word 2.
        @(negedge clk);
        awaddr = 32'h08; awvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h08; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp bvalid c%0d", c),  {31'h0, bvalid},  32'h1);
            chk($sformatf("bp rvalid c%0d", c),  {31'h0, rvalid},  32'h1);
            chk($sformatf("bp rdata c%0d", c),   rdata,            32'hA5A5_1234);
            chk($sformatf("bp awready c%0d", c), {31'h0, awready}, 32'h0);
            chk($sformatf("bp arready c%0d", c), {31'h0, arready}, 32'h0);
            if (c < 4) @(negedge clk);
        end
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        chk("bp bvalid released", {31'h0, bvalid}, 32'h0);
        chk("bp rvalid released", {31'h0, rvalid}, 32'h0);
        @(negedge clk);
        chk("bp single B", {31'h0, bvalid}, 32'h0);
        chk("bp single R", {31'h0, rvalid}, 32'h0);

        // Full sweep: no aliasing from out-of-range writes, no stray modifications.
        for (int w = 0; w < 16; w++) begin
            case (w)
                1:       sweep_exp = 32'hFF00_FF00;
                2:       sweep_exp = 32'h0BAD_F00D;
                3:       sweep_exp = 32'h1111_2222;
                15:      sweep_exp = 32'hCAFE_0000;
                default: sweep_exp = 32'h0;
            endcase
            do_read($sformatf("sweep w%0d", w), w * 4, sweep_exp);
        end

        // Reset mid-op: AW held, W pending.
        @(negedge clk);
        awaddr = 32'h14; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        chk("midrst aw held", {31'h0, awready}, 32'h0);
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wvalid = 1'b0;
            chk($sformatf("midrst W alone c%0d", c), {31'h0, bvalid}, 32'h0);
        end
        awaddr = 32'h14; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        chk("midrst new AW bvalid", {31'h0, bvalid}, 32'h1);
        @(negedge clk);
        bready = 1'b0;
        do_read("midrst rd_14", 32'h14, 32'h7777_7777);
        do_read("midrst mem cleared", 32'h08, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
